ides_word_align_ctrl: RTL and testbench
=======================================

// Module: ides_word_align_ctrl
// PURPOSE
//  Word-alignment controller for an IDES16 deserializer, running in the PCLK domain.
//  Resets the IDES, then issues single-cycle CALIB (bit-slip) pulses until the
//  parallel word q_i matches a known training pattern for MATCH_COUNT consecutive cycles.
//  Once locked, forwards registered payload words with a valid flag.
//  Sits between the IDES16 Q outputs and the downstream word consumer.
// PARAMETERS
//  WIDTH        10       bits of IDES output used (slice of Q0..Q15)
//  PATTERN      10'h0F8  training word; all WIDTH rotations are distinct
//  MATCH_COUNT  8        consecutive matches required for lock (>=1)
//  SETTLE       4        idle cycles after IDES reset release or CALIB pulse
//  RST_CYCLES   4        cycles ides_reset_o is held high
//  MAX_SLIPS    16       slips without lock before declaring failure
// PORTS
//  clk_i         in   1      PCLK from the IDES clock divider
//  nrst_i        in   1      asynchronous active-low reset
//  en_i          in   1      1 = run alignment; 0 = return to IDLE
//  relock_i      in   1      one-cycle pulse: restart alignment from LOCKED/FAIL
//  q_i           in   WIDTH  parallel word from IDES
//  ides_reset_o  out  1      drives IDES RESET
//  calib_o       out  1      drives IDES CALIB; one-cycle pulse per slip
//  locked_o      out  1      alignment achieved
//  fail_o        out  1      MAX_SLIPS exhausted without lock
//  slip_cnt_o    out  5      slips issued in current attempt
//  data_o        out  WIDTH  registered q_i while locked, else 0
//  data_valid_o  out  1      data_o valid
// BEHAVIOUR
//  Reset: state=IDLE; ides_reset_o=1, all other outputs 0; counters 0.
//  States: IDLE, IRST, SETTLE, CHECK, SLIP, LOCKED, FAIL.
//  IDLE: ides_reset_o=1; en_i=1 -> IRST.
//  IRST: ides_reset_o=1 for RST_CYCLES cycles, slip_cnt=0 -> SETTLE.
//  SETTLE: wait SETTLE cycles, match_cnt=0 -> CHECK.
//  CHECK: q_i==PATTERN -> match_cnt++; on reaching MATCH_COUNT -> LOCKED.
//   Mismatch: if slip_cnt==MAX_SLIPS -> FAIL, else -> SLIP.
//  SLIP: calib_o=1 for exactly this cycle; slip_cnt++ (saturates at 31) -> SETTLE.
//  LOCKED: locked_o=1; data_o<=q_i, data_valid_o=1 from the cycle after entry;
//   latency q_i->data_o = 1 cycle. No pattern checking while locked.
//  FAIL: fail_o=1; all other outputs held (ides_reset_o=0, calib_o=0).
//  relock_i in LOCKED or FAIL -> IRST next cycle; ignored in other states.
//  en_i=0 in any state -> IDLE next cycle; overrides relock_i; locked_o, fail_o,
//   data_valid_o, calib_o cleared on that cycle's edge; data_o cleared to 0.
//  calib_o is never high on two consecutive cycles nor while ides_reset_o=1.
//  slip_cnt_o retains its final value in LOCKED/FAIL; cleared only in IRST.
//  Async reset mid-operation: immediate return to reset values, no glitch pulse on calib_o.
// STRUCTURE
//  Shared package/header ides_align_pkg: state encodings, default PATTERN,
//   counter widths.
//  Single module; counters inline.
//  Optional sub-module ides_cycle_timer (load/expire down-counter)
//   shared by IRST and SETTLE.
// TESTING
//  Bench models IDES as 10-bit rotator of a serial stream with programmable offset;
//   CALIB rotates by one.
//  Offset 0, stream=PATTERN: no calib_o pulses; locked_o=1; slip_cnt_o=0.
//  Offset 3: exactly 3 calib_o pulses each followed by >=SETTLE idle cycles;
//   locked_o=1; slip_cnt_o=3.
//  Stream never matches (constant 10'h155): 16 slips then fail_o=1, locked_o=0;
//   relock_i -> ides_reset_o high 4 cycles.
//  Locked, payload 10'h2AA then 10'h155: data_o follows q_i one cycle later;
//   data_valid_o=1 throughout.
//  Match run broken at 7th of 8 matches -> one slip, match_cnt restarts;
//   lock after 8 fresh matches.
//  nrst_i low or en_i low mid-SLIP/LOCKED: outputs return to IDLE values;
//   calib_o=0; re-enable realigns from IRST.

Source files
------------

// File: rtl/ides_align_pkg.sv
// Shared types and constants for the IDES16 word-alignment controller.
package ides_align_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IRST,
        ST_SETTLE,
        ST_CHECK,
        ST_SLIP,
        ST_LOCKED,
        ST_FAIL
    } state_e;

    localparam logic [9:0] DEF_PATTERN = 10'h0F8;

    localparam int SLIP_W  = 5;
    localparam int MATCH_W = 8;
    localparam int TMR_W   = 8;

    localparam logic [SLIP_W-1:0] SLIP_SAT = '1;

endpackage

// File: rtl/ides_cycle_timer.sv
// Load/expire down-counter shared by the IDES reset and settle phases.
module ides_cycle_timer
    import ides_align_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk_i,
    input  logic         nrst_i,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/ides_word_align_ctrl.sv
// IDES16 word-alignment FSM: reset IDES, bit-slip until the training
// pattern is seen MATCH_COUNT times in a row, then forward payload.
module ides_word_align_ctrl
    import ides_align_pkg::*;
#(
    parameter int               WIDTH       = 10,
    parameter logic [WIDTH-1:0] PATTERN     = DEF_PATTERN,
    parameter int               MATCH_COUNT = 8,
    parameter int               SETTLE      = 4,
    parameter int               RST_CYCLES  = 4,
    parameter int               MAX_SLIPS   = 16
) (
    input  logic             clk_i,
    input  logic             nrst_i,
    input  logic             en_i,
    input  logic             relock_i,
    input  logic [WIDTH-1:0] q_i,
    output logic             ides_reset_o,
    output logic             calib_o,
    output logic             locked_o,
    output logic             fail_o,
    output logic [4:0]       slip_cnt_o,
    output logic [WIDTH-1:0] data_o,
    output logic             data_valid_o
);

    state_e               state_q, state_d;
    logic [SLIP_W-1:0]    slip_q, slip_d;
    logic [MATCH_W-1:0]   match_q, match_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 tmr_load;
    logic [TMR_W-1:0]     tmr_val;
    logic                 tmr_exp;

    ides_cycle_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk_i     (clk_i),
        .nrst_i    (nrst_i),
        .load_i    (tmr_load),
        .val_i     (tmr_val),
        .expired_o (tmr_exp)
    );

    always_comb begin
        state_d = state_q;
        slip_d  = slip_q;
        match_d = match_q;
        if (!en_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_IRST;
                ST_IRST: begin
                    if (tmr_exp) state_d = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (tmr_exp) state_d = ST_CHECK;
                end
                ST_CHECK: begin
                    if (q_i == PATTERN) begin
                        if (match_q == MATCH_W'(MATCH_COUNT - 1)) begin
                            state_d = ST_LOCKED;
                        end else begin
                            match_d = match_q + 1'b1;
                        end
                    end else if (slip_q == SLIP_W'(MAX_SLIPS)) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_SLIP;
                    end
                end
                ST_SLIP: begin
                    state_d = ST_SETTLE;
                    if (slip_q != SLIP_SAT) slip_d = slip_q + 1'b1;
                end
                ST_LOCKED, ST_FAIL: begin
                    if (relock_i) state_d = ST_IRST;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        // Counters clear on entry so the new attempt starts from zero.
        if (state_d == ST_IRST) slip_d = '0;
        if (state_d == ST_SETTLE) match_d = '0;
    end

    always_comb begin
        tmr_load = (state_d != state_q) &&
                   (state_d == ST_IRST || state_d == ST_SETTLE);
        tmr_val  = (state_d == ST_IRST) ? TMR_W'(RST_CYCLES - 1)
                                        : TMR_W'(SETTLE - 1);
    end

    always_comb begin
        valid_d = (state_q == ST_LOCKED) && (state_d == ST_LOCKED);
        data_d  = valid_d ? q_i : '0;
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q <= ST_IDLE;
            slip_q  <= '0;
            match_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            slip_q  <= slip_d;
            match_q <= match_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // Moore outputs decoded from the state register: glitch-free on reset.
    assign ides_reset_o = (state_q == ST_IDLE) || (state_q == ST_IRST);
    assign calib_o      = (state_q == ST_SLIP);
    assign locked_o     = (state_q == ST_LOCKED);
    assign fail_o       = (state_q == ST_FAIL);
    assign slip_cnt_o   = slip_q;
    assign data_o       = data_q;
    assign data_valid_o = valid_q;

endmodule

// File: tb/tb_ides_word_align_ctrl.sv
// Directed bench for ides_word_align_ctrl with a rotating IDES word model.
module tb_ides_word_align_ctrl;

    localparam logic [9:0] PAT = 10'h0F8;

    logic       clk_i = 1'b0;
    logic       nrst_i;
    logic       en_i;
    logic       relock_i;
    logic [9:0] q_i;
    logic       ides_reset_o;
    logic       calib_o;
    logic       locked_o;
    logic       fail_o;
    logic [4:0] slip_cnt_o;
    logic [9:0] data_o;
    logic       data_valid_o;

    int checks = 0;
    int errors = 0;
    int off = 0;
    logic use_man = 1'b0;
    logic [9:0] q_man = '0;
    int pulses, bad_gap, overlap, idle_run;
    logic seen;

    always #5 clk_i = ~clk_i;

    function automatic logic [9:0] rotl(input logic [9:0] x, input int s);
        logic [19:0] t;
        t = {x, x} << s;
        return t[19:10];
    endfunction

    assign q_i = use_man ? q_man : rotl(PAT, off);

    ides_word_align_ctrl dut (
        .clk_i        (clk_i),
        .nrst_i       (nrst_i),
        .en_i         (en_i),
        .relock_i     (relock_i),
        .q_i          (q_i),
        .ides_reset_o (ides_reset_o),
        .calib_o      (calib_o),
        .locked_o     (locked_o),
        .fail_o       (fail_o),
        .slip_cnt_o   (slip_cnt_o),
        .data_o       (data_o),
        .data_valid_o (data_valid_o)
    );

    task automatic tick();
        logic c;
        @(negedge clk_i);
        c = calib_o;
        if (c && ides_reset_o) overlap++;
        if (c) begin
            if (seen && idle_run < 4) bad_gap++;
            pulses++;
            seen = 1'b1;
            idle_run = 0;
        end else begin
            idle_run++;
        end
        @(posedge clk_i);
        #1;
        if (c) off = (off + 9) % 10;
    endtask

    task automatic start(input int o);
        en_i = 1'b0;
        relock_i = 1'b0;
        use_man = 1'b0;
        tick();
        off = o;
        pulses = 0;
        bad_gap = 0;
        overlap = 0;
        idle_run = 0;
        seen = 1'b0;
    endtask

    task automatic run_lock(input int budget, output int n);
        n = 0;
        while (!locked_o && !fail_o && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        nrst_i = 1'b0;
        en_i = 1'b0;
        relock_i = 1'b0;
        #12;
        checks++;
        if ({ides_reset_o, calib_o, locked_o, fail_o, data_valid_o} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 10000",
                     {ides_reset_o, calib_o, locked_o, fail_o, data_valid_o});
        end
        checks++;
        if (slip_cnt_o !== 5'd0 || data_o !== 10'd0) begin
            errors++;
            $display("FAIL reset_cnt_data got %0d/%h exp 0/0", slip_cnt_o, data_o);
        end
        @(posedge clk_i);
        #1;
        nrst_i = 1'b1;
    endtask

    task automatic test_offset0();
        int n;
        start(0);
        en_i = 1'b1;
        run_lock(100, n);
        checks++;
        if (n !== 17 || locked_o !== 1'b1) begin
            errors++;
            $display("FAIL off0_lock got n=%0d lk=%b exp n=17 lk=1", n, locked_o);
        end
        checks++;
        if (pulses !== 0 || slip_cnt_o !== 5'd0) begin
            errors++;
            $display("FAIL off0_slips got %0d/%0d exp 0/0", pulses, slip_cnt_o);
        end
        checks++;
        if (data_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL off0_entry_valid got %b exp 0", data_valid_o);
        end
    endtask

    task automatic test_offset3();
        int n;
        start(3);
        en_i = 1'b1;
        run_lock(300, n);
        checks++;
        if (n !== 35 || locked_o !== 1'b1) begin
            errors++;
            $display("FAIL off3_lock got n=%0d lk=%b exp n=35 lk=1", n, locked_o);
        end
        checks++;
        if (pulses !== 3 || slip_cnt_o !== 5'd3) begin
            errors++;
            $display("FAIL off3_slips got %0d/%0d exp 3/3", pulses, slip_cnt_o);
        end
        checks++;
        if (bad_gap !== 0 || overlap !== 0) begin
            errors++;
            $display("FAIL off3_gaps got %0d/%0d exp 0/0", bad_gap, overlap);
        end
    endtask

    task automatic test_fail_relock();
        int n;
        start(0);
        use_man = 1'b1;
        q_man = 10'h155;
        en_i = 1'b1;
        run_lock(400, n);
        checks++;
        if (n !== 106 || fail_o !== 1'b1 || locked_o !== 1'b0) begin
            errors++;
            $display("FAIL fail_state got n=%0d f=%b lk=%b exp n=106 f=1 lk=0",
                     n, fail_o, locked_o);
        end
        checks++;
        if (pulses !== 16 || slip_cnt_o !== 5'd16) begin
            errors++;
            $display("FAIL fail_slips got %0d/%0d exp 16/16", pulses, slip_cnt_o);
        end
        checks++;
        if (ides_reset_o !== 1'b0 || calib_o !== 1'b0) begin
            errors++;
            $display("FAIL fail_outs got %b%b exp 00", ides_reset_o, calib_o);
        end
        relock_i = 1'b1;
        tick();
        relock_i = 1'b0;
        checks++;
        if (fail_o !== 1'b0 || slip_cnt_o !== 5'd0) begin
            errors++;
            $display("FAIL relock_clear got f=%b s=%0d exp f=0 s=0", fail_o, slip_cnt_o);
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            checks++;
            if (ides_reset_o !== (i < 4)) begin
                errors++;
                $display("FAIL relock_rst[%0d] got %b exp %b", i, ides_reset_o, i < 4);
            end
        end
    endtask

    task automatic test_payload_disable();
        int n;
        start(0);
        en_i = 1'b1;
        run_lock(100, n);
        tick();
        checks++;
        if (data_valid_o !== 1'b1 || data_o !== PAT) begin
            errors++;
            $display("FAIL pay_first got v=%b d=%h exp v=1 d=%h", data_valid_o, data_o, PAT);
        end
        use_man = 1'b1;
        q_man = 10'h2AA;
        tick();
        checks++;
        if (data_o !== 10'h2AA || data_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL pay_2aa got %h v=%b exp 2aa v=1", data_o, data_valid_o);
        end
        q_man = 10'h155;
        tick();
        checks++;
        if (data_o !== 10'h155 || data_valid_o !== 1'b1 || locked_o !== 1'b1) begin
            errors++;
            $display("FAIL pay_155 got %h v=%b lk=%b exp 155 v=1 lk=1",
                     data_o, data_valid_o, locked_o);
        end
        en_i = 1'b0;
        tick();
        checks++;
        if ({ides_reset_o, calib_o, locked_o, data_valid_o} !== 4'b1000 ||
            data_o !== 10'd0) begin
            errors++;
            $display("FAIL dis_locked got %b d=%h exp 1000 d=0",
                     {ides_reset_o, calib_o, locked_o, data_valid_o}, data_o);
        end
    endtask

    task automatic test_broken_run();
        int n;
        start(0);
        en_i = 1'b1;
        n = 0;
        while (!locked_o && n < 200) begin
            tick();
            n++;
            if (n == 15) off = 1;
        end
        checks++;
        if (n !== 29 || locked_o !== 1'b1) begin
            errors++;
            $display("FAIL broken_lock got n=%0d lk=%b exp n=29 lk=1", n, locked_o);
        end
        checks++;
        if (pulses !== 1 || slip_cnt_o !== 5'd1) begin
            errors++;
            $display("FAIL broken_slips got %0d/%0d exp 1/1", pulses, slip_cnt_o);
        end
    endtask

    task automatic test_disable_slip();
        int n;
        start(0);
        use_man = 1'b1;
        q_man = 10'h155;
        en_i = 1'b1;
        n = 0;
        while (!calib_o && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (calib_o !== 1'b1) begin
            errors++;
            $display("FAIL dslip_reach got %b exp 1", calib_o);
        end
        en_i = 1'b0;
        tick();
        checks++;
        if ({ides_reset_o, calib_o, locked_o, fail_o} !== 4'b1000) begin
            errors++;
            $display("FAIL dslip_idle got %b exp 1000",
                     {ides_reset_o, calib_o, locked_o, fail_o});
        end
        use_man = 1'b0;
        off = 2;
        pulses = 0;
        seen = 1'b0;
        en_i = 1'b1;
        run_lock(200, n);
        checks++;
        if (n !== 29 || locked_o !== 1'b1 || slip_cnt_o !== 5'd2) begin
            errors++;
            $display("FAIL dslip_relock got n=%0d lk=%b s=%0d exp 29/1/2",
                     n, locked_o, slip_cnt_o);
        end
    endtask

    task automatic test_async_reset();
        int n;
        start(0);
        use_man = 1'b1;
        q_man = 10'h155;
        en_i = 1'b1;
        n = 0;
        while (!calib_o && n < 100) begin
            tick();
            n++;
        end
        #2;
        nrst_i = 1'b0;
        #1;
        checks++;
        if ({ides_reset_o, calib_o, locked_o, fail_o} !== 4'b1000 ||
            slip_cnt_o !== 5'd0) begin
            errors++;
            $display("FAIL arst_outs got %b s=%0d exp 1000 s=0",
                     {ides_reset_o, calib_o, locked_o, fail_o}, slip_cnt_o);
        end
        @(posedge clk_i);
        #1;
        nrst_i = 1'b1;
        use_man = 1'b0;
        off = 1;
        pulses = 0;
        overlap = 0;
        seen = 1'b0;
        run_lock(200, n);
        checks++;
        if (locked_o !== 1'b1 || slip_cnt_o !== 5'd1 || pulses !== 1 || overlap !== 0) begin
            errors++;
            $display("FAIL arst_relock got lk=%b s=%0d p=%0d o=%0d exp 1/1/1/0",
                     locked_o, slip_cnt_o, pulses, overlap);
        end
    endtask

    initial begin
        pulses = 0;
        bad_gap = 0;
        overlap = 0;
        idle_run = 0;
        seen = 1'b0;
        test_reset();
        test_offset0();
        test_offset3();
        test_fail_relock();
        test_payload_disable();
        test_broken_run();
        test_disable_slip();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
